aib_mac_link_seq: RTL and testbench
===================================

Name: aib_mac_link_seq

Overview:
- MAC-side link bring-up sequencer. It drives the MAC control pins of the AIB leader interface: power-on-reset, conf_done, per-channel adapter reset and mac_rdy.
- It monitors device detect, far-side mac_rdy and the four transfer_en vectors, then declares the link up.
- It sits directly upstream of the per-channel MAC signals, in both the DV harness and the MAC shell.
- It includes timeout/retry handling and link-loss recovery.

Parameters:
- TOTAL_CHNL_NUM, 24, number of AIB channels.
- POR_CYC, 16, cycles o_m_power_on_reset is held asserted.
- STEP_CYC, 8, dwell cycles after conf_done and after adapter reset release.
- TIMEOUT_CYC, 4096, maximum wait in DET/XFER states; counter width is $clog2(TIMEOUT_CYC).
- MAX_RETRY, 3, retries before FAIL.

Ports:
- i_osc_clk  in  1  sequencer clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  single-cycle start pulse, i_osc_clk domain.
- i_chnl_en  in  TOTAL_CHNL_NUM  channel enable mask, sampled on accepted start.
- i_m_device_detect  in  1  far-side device detect (async).
- i_fs_mac_rdy  in  TOTAL_CHNL_NUM  far-side mac ready (async).
- i_ms_tx_transfer_en, i_ms_rx_transfer_en, i_sl_tx_transfer_en, i_sl_rx_transfer_en  in  TOTAL_CHNL_NUM each  transfer enables (async).
- o_m_power_on_reset  out  1  drives DUT i_m_power_on_reset; active high.
- o_conf_done  out  1  drives DUT i_conf_done.
- o_ns_adapter_rstn  out  TOTAL_CHNL_NUM  per-channel adapter reset, active low.
- o_ns_mac_rdy  out  TOTAL_CHNL_NUM  per-channel near-side mac ready.
- o_link_up  out  1  all enabled channels transferring.
- o_link_fail  out  1  retries exhausted.
- o_retry_cnt  out  2  retries consumed.
- o_state  out  4  current state encoding.

Behaviour:
- Reset values:
  - o_m_power_on_reset=1; o_conf_done=0; o_ns_adapter_rstn=0; o_ns_mac_rdy=0.
  - o_link_up=0; o_link_fail=0; o_retry_cnt=0; o_state=IDLE.
  - Enable mask register=0; all synchroniser flops=0.
- Synchronisers: all async inputs pass through 2-flop synchronisers, so there is 2 cycles of latency before the FSM sees them.
- Channel qualifier: "all ready" means that for every channel with its mask bit =1, fs_mac_rdy and all four transfer_en are 1.
- States: IDLE=0, POR=1, DET=2, CONF=3, ADPT=4, MACRDY=5, XFER=6, UP=7, FAIL=8.
- IDLE:
  - i_start latches i_chnl_en, clears retry count, goes to POR.
  - A latched mask of 0 goes directly to FAIL.
- POR: o_m_power_on_reset=1 for exactly POR_CYC cycles, then deasserts on entry to DET.
- DET:
  - Synced device_detect=1 goes to CONF.
  - Timeout goes to RETRY handling.
- CONF: o_conf_done=1 from entry, held thereafter; after STEP_CYC cycles, go to ADPT.
- ADPT: o_ns_adapter_rstn=mask from entry; after STEP_CYC cycles, go to MACRDY.
- MACRDY: o_ns_mac_rdy=mask from entry; go to XFER on the next cycle.
- XFER:
  - All-ready in a sampled cycle goes to UP.
  - Timeout goes to RETRY handling.
  - Disabled channels' outputs stay 0 throughout.
- UP:
  - o_link_up=1 registered on entry.
  - All-ready dropping in any cycle clears o_link_up on the next cycle and triggers RETRY.
- RETRY handling:
  - If o_retry_cnt==MAX_RETRY, go to FAIL.
  - Otherwise increment o_retry_cnt and go to POR.
  - In the same transition cycle, restore o_m_power_on_reset=1, o_conf_done=0, adapter_rstn=0, mac_rdy=0.
- Timeout:
  - The cycle counter clears on every state entry.
  - In DET/XFER, timeout fires when the counter reaches TIMEOUT_CYC-1 without the exit condition.
  - If the exit condition and timeout occur in the same cycle, the exit condition wins.
- FAIL:
  - o_link_fail=1; all control outputs held at reset values.
  - i_start clears o_link_fail, re-latches the mask, clears the retry count and goes to POR.
- i_start in any state other than IDLE/FAIL is ignored.
- Mask changes after start are ignored until the next accepted start.
- i_rst_n assertion mid-sequence immediately forces all outputs to reset values, regardless of state.
- o_retry_cnt saturates at MAX_RETRY.

Test Plan:
- Nominal bring-up:
  - Stimulus: mask=24'hFFFFFF; detect rises 5 cycles after POR ends; all transfer_en/fs_mac_rdy rise 20 cycles after mac_rdy.
  - Required: POR high exactly 16 cycles; o_link_up=1 exactly 3 cycles after inputs rise (2 sync + 1 register); o_retry_cnt=0.
- Partial mask:
  - Stimulus: mask=24'h00000F; ready only on channels 0-3.
  - Required: o_ns_adapter_rstn=o_ns_mac_rdy=24'h00000F; link up.
  - Required: channel 5 toggling transfer_en has no effect.
- Detect timeout:
  - Stimulus: device_detect held 0.
  - Required: 3 retries, each after 4096 DET cycles; then o_link_fail=1, o_retry_cnt=3, o_state=8.
  - Required: i_start then restarts with o_link_fail=0.
- Link loss:
  - Stimulus: in UP, drop sl_rx_transfer_en[2] for 1 cycle.
  - Required: o_link_up falls; o_m_power_on_reset=1; o_retry_cnt=1.
  - Required: re-bring-up succeeds when inputs recover.
- Zero mask / busy start:
  - Stimulus: i_start with mask=0.
  - Required: FAIL next cycle.
  - Stimulus: i_start pulsed during XFER.
  - Required: state unchanged.
- Reset mid-op:
  - Stimulus: assert i_rst_n=0 in ADPT.
  - Required: all outputs return to reset values asynchronously; o_state=0.

Source files
------------

// File: rtl/aib_mac_link_seq_if.sv
// MAC control/status bundle between the link bring-up sequencer and the AIB leader pins.
interface aib_mac_link_seq_if #(
  parameter int TOTAL_CHNL_NUM = 24
);
  logic                      i_start;
  logic [TOTAL_CHNL_NUM-1:0] i_chnl_en;
  logic                      i_m_device_detect;
  logic [TOTAL_CHNL_NUM-1:0] i_fs_mac_rdy;
  logic [TOTAL_CHNL_NUM-1:0] i_ms_tx_transfer_en;
  logic [TOTAL_CHNL_NUM-1:0] i_ms_rx_transfer_en;
  logic [TOTAL_CHNL_NUM-1:0] i_sl_tx_transfer_en;
  logic [TOTAL_CHNL_NUM-1:0] i_sl_rx_transfer_en;

  logic                      o_m_power_on_reset;
  logic                      o_conf_done;
  logic [TOTAL_CHNL_NUM-1:0] o_ns_adapter_rstn;
  logic [TOTAL_CHNL_NUM-1:0] o_ns_mac_rdy;
  logic                      o_link_up;
  logic                      o_link_fail;
  logic [1:0]                o_retry_cnt;
  logic [3:0]                o_state;

  modport master (
    output i_start, i_chnl_en, i_m_device_detect, i_fs_mac_rdy,
           i_ms_tx_transfer_en, i_ms_rx_transfer_en, i_sl_tx_transfer_en, i_sl_rx_transfer_en,
    input  o_m_power_on_reset, o_conf_done, o_ns_adapter_rstn, o_ns_mac_rdy,
           o_link_up, o_link_fail, o_retry_cnt, o_state
  );

  modport slave (
    input  i_start, i_chnl_en, i_m_device_detect, i_fs_mac_rdy,
           i_ms_tx_transfer_en, i_ms_rx_transfer_en, i_sl_tx_transfer_en, i_sl_rx_transfer_en,
    output o_m_power_on_reset, o_conf_done, o_ns_adapter_rstn, o_ns_mac_rdy,
           o_link_up, o_link_fail, o_retry_cnt, o_state
  );
endinterface

// File: rtl/aib_mac_link_seq.sv
// AIB leader MAC-side bring-up sequencer: POR, conf_done, adapter reset and mac_rdy
// sequencing, qualified by synchronised detect/transfer status, with timeout retry.
module aib_mac_link_seq #(
  parameter int TOTAL_CHNL_NUM = 24,
  parameter int POR_CYC        = 16,
  parameter int STEP_CYC       = 8,
  parameter int TIMEOUT_CYC    = 4096,
  parameter int MAX_RETRY      = 3
) (
  input  logic              i_osc_clk,
  input  logic              i_rst_n,
  aib_mac_link_seq_if.slave bus
);
  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] POR_LAST  = CNT_W'(POR_CYC - 1);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [1:0]       RETRY_MAX = 2'(MAX_RETRY);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_POR    = 4'd1;
  localparam logic [3:0] S_DET    = 4'd2;
  localparam logic [3:0] S_CONF   = 4'd3;
  localparam logic [3:0] S_ADPT   = 4'd4;
  localparam logic [3:0] S_MACRDY = 4'd5;
  localparam logic [3:0] S_XFER   = 4'd6;
  localparam logic [3:0] S_UP     = 4'd7;
  localparam logic [3:0] S_FAIL   = 4'd8;

  logic [3:0]                     state_q, state_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [TOTAL_CHNL_NUM-1:0]      mask_q, mask_d;
  logic [1:0]                     retry_q, retry_d;
  logic                           por_q, por_d;
  logic                           conf_q, conf_d;
  logic [TOTAL_CHNL_NUM-1:0]      adpt_q, adpt_d;
  logic [TOTAL_CHNL_NUM-1:0]      mrdy_q, mrdy_d;
  logic                           up_q, up_d;
  logic                           fail_q, fail_d;

  logic [TOTAL_CHNL_NUM-1:0][4:0] lane_raw, lane_s1_q, lane_s2_q;
  logic [TOTAL_CHNL_NUM-1:0]      lane_ok;
  logic                           det_s1_q, det_s2_q;
  logic                           all_rdy, timeout, do_retry;

  // A lane is good when masked off, or when its synced fs_mac_rdy and all four transfer enables are high.
  for (genvar g = 0; g < TOTAL_CHNL_NUM; g++) begin : g_lane
    assign lane_raw[g] = {bus.i_fs_mac_rdy[g], bus.i_ms_tx_transfer_en[g], bus.i_ms_rx_transfer_en[g],
                          bus.i_sl_tx_transfer_en[g], bus.i_sl_rx_transfer_en[g]};
    assign lane_ok[g]  = ~mask_q[g] | (&lane_s2_q[g]);
  end

  assign all_rdy = &lane_ok;
  assign timeout = (cnt_q == TO_LAST);

  always_ff @(posedge i_osc_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lane_s1_q <= '0;
      lane_s2_q <= '0;
      det_s1_q  <= 1'b0;
      det_s2_q  <= 1'b0;
    end else begin
      lane_s1_q <= lane_raw;
      lane_s2_q <= lane_s1_q;
      det_s1_q  <= bus.i_m_device_detect;
      det_s2_q  <= det_s1_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    retry_d  = retry_q;
    por_d    = por_q;
    conf_d   = conf_q;
    adpt_d   = adpt_q;
    mrdy_d   = mrdy_q;
    up_d     = up_q;
    fail_d   = fail_q;
    do_retry = 1'b0;
    case (state_q)
      S_IDLE, S_FAIL: if (bus.i_start) begin
        mask_d  = bus.i_chnl_en;
        retry_d = 2'd0;
        if (bus.i_chnl_en == '0) begin
          state_d = S_FAIL;
          fail_d  = 1'b1;
        end else begin
          state_d = S_POR;
          fail_d  = 1'b0;
        end
      end
      S_POR: if (cnt_q == POR_LAST) begin
        state_d = S_DET;
        por_d   = 1'b0;
      end
      S_DET: begin
        if (det_s2_q) begin
          state_d = S_CONF;
          conf_d  = 1'b1;
        end else if (timeout) begin
          do_retry = 1'b1;
        end
      end
      S_CONF: if (cnt_q == STEP_LAST) begin
        state_d = S_ADPT;
        adpt_d  = mask_q;
      end
      S_ADPT: if (cnt_q == STEP_LAST) begin
        state_d = S_MACRDY;
        mrdy_d  = mask_q;
      end
      S_MACRDY: state_d = S_XFER;
      S_XFER: begin
        if (all_rdy) begin
          state_d = S_UP;
          up_d    = 1'b1;
        end else if (timeout) begin
          do_retry = 1'b1;
        end
      end
      S_UP: if (!all_rdy) do_retry = 1'b1;
      default: state_d = S_IDLE;
    endcase

    // Abandoning an attempt puts every control pin back to its reset value in the same edge.
    if (do_retry) begin
      por_d  = 1'b1;
      conf_d = 1'b0;
      adpt_d = '0;
      mrdy_d = '0;
      up_d   = 1'b0;
      if (retry_q == RETRY_MAX) begin
        state_d = S_FAIL;
        fail_d  = 1'b1;
      end else begin
        state_d = S_POR;
        retry_d = retry_q + 2'd1;
      end
    end

    cnt_d = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge i_osc_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mask_q  <= '0;
      retry_q <= 2'd0;
      por_q   <= 1'b1;
      conf_q  <= 1'b0;
      adpt_q  <= '0;
      mrdy_q  <= '0;
      up_q    <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      retry_q <= retry_d;
      por_q   <= por_d;
      conf_q  <= conf_d;
      adpt_q  <= adpt_d;
      mrdy_q  <= mrdy_d;
      up_q    <= up_d;
      fail_q  <= fail_d;
    end
  end

  assign bus.o_m_power_on_reset = por_q;
  assign bus.o_conf_done        = conf_q;
  assign bus.o_ns_adapter_rstn  = adpt_q;
  assign bus.o_ns_mac_rdy       = mrdy_q;
  assign bus.o_link_up          = up_q;
  assign bus.o_link_fail        = fail_q;
  assign bus.o_retry_cnt        = retry_q;
  assign bus.o_state            = state_q;
endmodule

// File: tb/tb_aib_mac_link_seq.sv
// Bench for aib_mac_link_seq: phase-level reference model compared every cycle, plus directed literal checks.
module tb_aib_mac_link_seq;
  localparam int N           = 24;
  localparam int POR_CYC     = 16;
  localparam int STEP_CYC    = 8;
  localparam int TIMEOUT_CYC = 4096;
  localparam int MAX_RETRY   = 3;

  localparam int P_IDLE = 0, P_POR = 1, P_DET = 2, P_CONF = 3, P_ADPT = 4;
  localparam int P_MACRDY = 5, P_XFER = 6, P_UP = 7, P_FAIL = 8;

  typedef struct packed {
    logic         det;
    logic [N-1:0] fs, mtx, mrx, stx, srx;
  } raw_t;

  typedef struct packed {
    int           ph;
    int           t;
    int           retry;
    logic [N-1:0] mask;
  } mst_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  aib_mac_link_seq_if #(.TOTAL_CHNL_NUM(N)) bus ();

  aib_mac_link_seq #(
    .TOTAL_CHNL_NUM(N), .POR_CYC(POR_CYC), .STEP_CYC(STEP_CYC),
    .TIMEOUT_CYC(TIMEOUT_CYC), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .i_osc_clk(clk),
    .i_rst_n  (rst_n),
    .bus      (bus)
  );

  // ---------------- reference model ----------------
  function automatic logic all_ready(raw_t r, logic [N-1:0] m);
    for (int i = 0; i < N; i++)
      if (m[i] && !(r.fs[i] && r.mtx[i] && r.mrx[i] && r.stx[i] && r.srx[i])) return 1'b0;
    return 1'b1;
  endfunction

  // One clock of the bring-up procedure; "seen" is what the inputs looked like two edges ago.
  function automatic mst_t model_step(mst_t s, raw_t seen, logic start, logic [N-1:0] en_in);
    mst_t n;
    logic give_up;
    logic timed_out;
    n         = s;
    give_up   = 1'b0;
    timed_out = (s.t + 1 >= TIMEOUT_CYC);
    case (s.ph)
      P_IDLE, P_FAIL: if (start) begin
        n.mask  = en_in;
        n.retry = 0;
        n.ph    = (en_in == 0) ? P_FAIL : P_POR;
      end
      P_POR:    if (s.t + 1 == POR_CYC) n.ph = P_DET;
      P_DET:    if (seen.det) n.ph = P_CONF; else give_up = timed_out;
      P_CONF:   if (s.t + 1 == STEP_CYC) n.ph = P_ADPT;
      P_ADPT:   if (s.t + 1 == STEP_CYC) n.ph = P_MACRDY;
      P_MACRDY: n.ph = P_XFER;
      P_XFER:   if (all_ready(seen, s.mask)) n.ph = P_UP; else give_up = timed_out;
      P_UP:     give_up = !all_ready(seen, s.mask);
      default:  n.ph = P_IDLE;
    endcase
    if (give_up) begin
      if (s.retry >= MAX_RETRY) n.ph = P_FAIL;
      else begin
        n.ph    = P_POR;
        n.retry = s.retry + 1;
      end
    end
    n.t = (n.ph == s.ph) ? s.t + 1 : 0;
    return n;
  endfunction

  // Pin values follow purely from which phase the procedure is in.
  function automatic logic [57:0] exp_out(mst_t s);
    logic         por, conf, up, fail;
    logic [N-1:0] adpt, mrdy;
    por  = (s.ph == P_IDLE) || (s.ph == P_POR) || (s.ph == P_FAIL);
    conf = (s.ph >= P_CONF) && (s.ph <= P_UP);
    adpt = ((s.ph >= P_ADPT) && (s.ph <= P_UP)) ? s.mask : {N{1'b0}};
    mrdy = ((s.ph >= P_MACRDY) && (s.ph <= P_UP)) ? s.mask : {N{1'b0}};
    up   = (s.ph == P_UP);
    fail = (s.ph == P_FAIL);
    return {por, conf, adpt, mrdy, up, fail, 2'(s.retry), 4'(s.ph)};
  endfunction

  raw_t        cur_raw, h0, h1;
  mst_t        m;
  logic [57:0] exp_v, got_v;

  assign cur_raw = {bus.i_m_device_detect, bus.i_fs_mac_rdy, bus.i_ms_tx_transfer_en,
                    bus.i_ms_rx_transfer_en, bus.i_sl_tx_transfer_en, bus.i_sl_rx_transfer_en};
  assign exp_v   = exp_out(m);
  assign got_v   = {bus.o_m_power_on_reset, bus.o_conf_done, bus.o_ns_adapter_rstn, bus.o_ns_mac_rdy,
                    bus.o_link_up, bus.o_link_fail, bus.o_retry_cnt, bus.o_state};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m  <= '0;
      h0 <= '0;
      h1 <= '0;
    end else begin
      m  <= model_step(m, h1, bus.i_start, bus.i_chnl_en);
      h1 <= h0;
      h0 <= cur_raw;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL model_cmp @%0t: dut %h model %h", $time, got_v, exp_v);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic wait_state(input int s, input int budget, input string name);
    int n;
    n = 0;
    while (bus.o_state != 4'(s) && n < budget) begin
      step();
      n++;
    end
    chk(name, 64'(bus.o_state), 64'(s));
  endtask

  task automatic set_rdy(input logic [N-1:0] v);
    bus.i_fs_mac_rdy        = v;
    bus.i_ms_tx_transfer_en = v;
    bus.i_ms_rx_transfer_en = v;
    bus.i_sl_tx_transfer_en = v;
    bus.i_sl_rx_transfer_en = v;
  endtask

  task automatic start(input logic [N-1:0] msk);
    bus.i_chnl_en = msk;
    bus.i_start   = 1'b1;
    step();
    bus.i_start   = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  function automatic logic [N-1:0] rvec(logic [N-1:0] msk, logic on);
    return (N'($urandom) & ~msk) | (on ? msk : {N{1'b0}});
  endfunction

  // ---------------- directed + random stimulus ----------------
  int           n, dd, on_at;
  logic [N-1:0] rm;

  initial begin
    bus.i_start = 1'b0;
    bus.i_chnl_en = '0;
    bus.i_m_device_detect = 1'b0;
    set_rdy('0);
    repeat (3) step();
    chk("rst_por",   64'(bus.o_m_power_on_reset), 64'd1);
    chk("rst_conf",  64'(bus.o_conf_done), 64'd0);
    chk("rst_adpt",  64'(bus.o_ns_adapter_rstn), 64'd0);
    chk("rst_mrdy",  64'(bus.o_ns_mac_rdy), 64'd0);
    chk("rst_flags", 64'({bus.o_link_up, bus.o_link_fail, bus.o_retry_cnt}), 64'd0);
    chk("rst_state", 64'(bus.o_state), 64'd0);
    rst_n = 1'b1;
    step();

    // Nominal bring-up, all channels
    start(24'hFFFFFF);
    n = 0;
    while (bus.o_state == 4'd1 && n < 100) begin
      n++;
      step();
    end
    chk("por_len", 64'(n), 64'd16);
    chk("por_deassert", 64'(bus.o_m_power_on_reset), 64'd0);
    repeat (4) step();
    bus.i_m_device_detect = 1'b1;
    wait_state(P_XFER, 100, "nom_reach_xfer");
    chk("nom_adpt", 64'(bus.o_ns_adapter_rstn), 64'hFFFFFF);
    chk("nom_mrdy", 64'(bus.o_ns_mac_rdy), 64'hFFFFFF);
    chk("nom_conf", 64'(bus.o_conf_done), 64'd1);
    repeat (19) step();
    set_rdy(24'hFFFFFF);
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.o_link_up && n < 20);
    chk("nom_up_latency", 64'(n), 64'd3);
    chk("nom_retry", 64'(bus.o_retry_cnt), 64'd0);

    // Partial mask: lanes 0-3 only, lane 5 chatter ignored
    pulse_reset();
    set_rdy(24'h00000F);
    start(24'h00000F);
    wait_state(P_UP, 200, "part_reach_up");
    chk("part_adpt", 64'(bus.o_ns_adapter_rstn), 64'h00000F);
    chk("part_mrdy", 64'(bus.o_ns_mac_rdy), 64'h00000F);
    for (int i = 0; i < 6; i++) begin
      bus.i_ms_tx_transfer_en[5] = ~bus.i_ms_tx_transfer_en[5];
      step();
    end
    bus.i_ms_tx_transfer_en[5] = 1'b0;
    repeat (3) step();
    chk("part_ch5_ignored", 64'({bus.o_link_up, bus.o_state}), 64'h17);

    // Link loss: one-cycle drop of sl_rx_transfer_en[2]
    bus.i_sl_rx_transfer_en[2] = 1'b0;
    step();
    bus.i_sl_rx_transfer_en[2] = 1'b1;
    wait_state(P_POR, 10, "loss_to_por");
    chk("loss_up", 64'(bus.o_link_up), 64'd0);
    chk("loss_por", 64'(bus.o_m_power_on_reset), 64'd1);
    chk("loss_retry", 64'(bus.o_retry_cnt), 64'd1);
    wait_state(P_UP, 200, "loss_recover");
    chk("loss_recover_retry", 64'(bus.o_retry_cnt), 64'd1);

    // Zero mask, then busy start ignored in XFER
    pulse_reset();
    set_rdy('0);
    start('0);
    chk("zero_state", 64'(bus.o_state), 64'd8);
    chk("zero_fail", 64'(bus.o_link_fail), 64'd1);
    start(24'hFFFFFF);
    chk("fail_restart", 64'({bus.o_link_fail, bus.o_state}), 64'h01);
    wait_state(P_XFER, 100, "busy_reach_xfer");
    start(24'h000001);
    chk("busy_state", 64'(bus.o_state), 64'd6);
    set_rdy(24'hFFFFFF);
    wait_state(P_UP, 20, "busy_reach_up");
    chk("busy_mask_kept", 64'(bus.o_ns_mac_rdy), 64'hFFFFFF);

    // Reset mid-operation (ADPT)
    pulse_reset();
    start(24'h0F0F0F);
    wait_state(P_ADPT, 100, "mid_reach_adpt");
    chk("mid_adpt", 64'(bus.o_ns_adapter_rstn), 64'h0F0F0F);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ctl", 64'({bus.o_m_power_on_reset, bus.o_conf_done, bus.o_link_up, bus.o_link_fail}), 64'h8);
    chk("mid_rst_vec", 64'({bus.o_ns_adapter_rstn, bus.o_ns_mac_rdy}), 64'd0);
    chk("mid_rst_state", 64'({bus.o_retry_cnt, bus.o_state}), 64'd0);
    step();
    rst_n = 1'b1;
    step();

    // Detect timeout: four attempts, then FAIL
    bus.i_m_device_detect = 1'b0;
    set_rdy('0);
    start(24'hFFFFFF);
    wait_state(P_DET, 50, "to_reach_det");
    n = 0;
    while (bus.o_state == 4'd2 && n < 5000) begin
      n++;
      step();
    end
    chk("det_len", 64'(n), 64'd4096);
    chk("det_retry1", 64'({bus.o_retry_cnt, bus.o_state}), 64'h11);
    wait_state(P_FAIL, 20000, "to_reach_fail");
    chk("to_fail", 64'(bus.o_link_fail), 64'd1);
    chk("to_retry", 64'(bus.o_retry_cnt), 64'd3);
    chk("to_por", 64'(bus.o_m_power_on_reset), 64'd1);
    start(24'hFFFFFF);
    chk("to_restart", 64'({bus.o_link_fail, bus.o_retry_cnt, bus.o_state}), 64'h01);

    // Randomised bring-ups with noise on masked-off lanes, glitches and stray starts
    for (int it = 0; it < 6; it++) begin
      pulse_reset();
      bus.i_m_device_detect = 1'b0;
      set_rdy('0);
      rm = N'($urandom);
      if (rm == '0) rm = 24'h000100;
      dd    = $urandom_range(16, 50);
      on_at = dd + 20 + $urandom_range(0, 60);
      start(rm);
      for (int c = 0; c < 220; c++) begin
        if (c == dd) bus.i_m_device_detect = 1'b1;
        bus.i_fs_mac_rdy        = rvec(rm, c >= on_at);
        bus.i_ms_tx_transfer_en = rvec(rm, c >= on_at);
        bus.i_ms_rx_transfer_en = rvec(rm, c >= on_at);
        bus.i_sl_tx_transfer_en = rvec(rm, c >= on_at);
        bus.i_sl_rx_transfer_en = rvec(rm, c >= on_at);
        if (c >= on_at && $urandom_range(0, 49) == 0)
          bus.i_sl_tx_transfer_en[$urandom_range(0, N-1)] = 1'b0;
        bus.i_start   = ($urandom_range(0, 59) == 0);
        bus.i_chnl_en = ($urandom_range(0, 3) == 0) ? {N{1'b0}} : N'($urandom);
        step();
      end
      bus.i_start = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
